// File: rtl/wb_master_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave between NUM_M masters, with
// LOCK-based ownership hold and a watchdog that terminates hung cycles with ERR.
module wb_master_arbiter #(
  parameter int NUM_M   = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_M-1:0]        m_cyc_i,
  input  logic [NUM_M-1:0]        m_stb_i,
  input  logic [NUM_M-1:0]        m_we_i,
  input  logic [NUM_M-1:0]        m_lock_i,
  input  logic [NUM_M*AW-1:0]     m_adr_i,
  input  logic [NUM_M*DW-1:0]     m_dat_i,
  input  logic [NUM_M*DW/8-1:0]   m_sel_i,
  output logic [NUM_M-1:0]        m_ack_o,
  output logic [NUM_M-1:0]        m_err_o,
  output logic [NUM_M-1:0]        m_rty_o,
  output logic [DW-1:0]           m_dat_o,
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  output logic                    s_we_o,
  output logic                    s_lock_o,
  output logic [AW-1:0]           s_adr_o,
  output logic [DW-1:0]           s_dat_o,
  output logic [DW/8-1:0]         s_sel_o,
  input  logic                    s_ack_i,
  input  logic                    s_err_i,
  input  logic                    s_rty_i,
  input  logic [DW-1:0]           s_dat_i,
  output logic [NUM_M-1:0]        gnt_o,
  output logic                    busy_o
);
  localparam int SW  = DW / 8;
  localparam int LW  = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int CW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TM1 = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic {IDLE, OWN} state_t;

  state_t           state, state_n;
  logic [NUM_M-1:0] gnt, gnt_n;
  logic [LW-1:0]    last, last_n, win;
  logic [CW-1:0]    wd_cnt;
  logic             to_err;
  logic             own_cyc, own_stb, own_lock, own_we, resp;
  logic [AW-1:0]    own_adr;
  logic [DW-1:0]    own_dat;
  logic [SW-1:0]    own_sel;

  // Datapath is an AND-OR mux on the one-hot grant, so idle drives zeros.
  always_comb begin
    own_adr = '0;
    own_dat = '0;
    own_sel = '0;
    for (int k = 0; k < NUM_M; k++) begin
      if (gnt[k]) begin
        own_adr = own_adr | m_adr_i[k*AW +: AW];
        own_dat = own_dat | m_dat_i[k*DW +: DW];
        own_sel = own_sel | m_sel_i[k*SW +: SW];
      end
    end
  end

  assign own_cyc  = |(m_cyc_i  & gnt);
  assign own_stb  = |(m_stb_i  & gnt);
  assign own_lock = |(m_lock_i & gnt);
  assign own_we   = |(m_we_i   & gnt);
  assign resp     = s_ack_i | s_err_i | s_rty_i;

  // Round-robin search starting just after the last winner.
  always_comb begin
    int idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    win   = last;
    for (int i = 1; i <= NUM_M; i++) begin
      idx = (int'(last) + i) % NUM_M;
      if (!found && m_cyc_i[idx]) begin
        found = 1'b1;
        win   = LW'(idx);
      end
    end
  end

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    last_n  = last;
    case (state)
      IDLE: if (|m_cyc_i) begin
        state_n    = OWN;
        gnt_n      = '0;
        gnt_n[win] = 1'b1;
        last_n     = win;
      end
      OWN: if (!own_cyc && !own_lock) begin
        state_n = IDLE;
        gnt_n   = '0;
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      gnt   <= '0;
      last  <= LW'(NUM_M - 1);
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      last  <= last_n;
    end
  end

  // s_stb_o is already masked in the ERR cycle, so the count restarts there.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt <= '0;
      to_err <= 1'b0;
    end else if (TIMEOUT == 0 || !s_stb_o || resp) begin
      wd_cnt <= '0;
      to_err <= 1'b0;
    end else if (wd_cnt == CW'(TM1)) begin
      wd_cnt <= '0;
      to_err <= 1'b1;
    end else begin
      wd_cnt <= wd_cnt + CW'(1);
    end
  end

  assign s_cyc_o  = own_cyc;
  assign s_stb_o  = own_stb & own_cyc & ~to_err;
  assign s_we_o   = own_we;
  assign s_lock_o = own_lock;
  assign s_adr_o  = own_adr;
  assign s_dat_o  = own_dat;
  assign s_sel_o  = own_sel;

  assign m_ack_o  = gnt & {NUM_M{s_ack_i & ~to_err}};
  assign m_rty_o  = gnt & {NUM_M{s_rty_i & ~to_err}};
  assign m_err_o  = gnt & {NUM_M{s_err_i | to_err}};
  assign m_dat_o  = s_dat_i;

  assign gnt_o    = gnt;
  assign busy_o   = (state == OWN);
endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed + randomized bench for wb_master_arbiter with a cycle-level
// reference model (owner/last/silent-strobe run length) kept in plain ints.
module tb_wb_master_arbiter;
  localparam int NM = 2;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [NM-1:0]   m_cyc_i, m_stb_i, m_we_i, m_lock_i;
  logic [NM*32-1:0] m_adr_i, m_dat_i;
  logic [NM*4-1:0] m_sel_i;
  logic [NM-1:0]   m_ack_o, m_err_o, m_rty_o;
  logic [31:0]     m_dat_o;
  logic            s_cyc_o, s_stb_o, s_we_o, s_lock_o;
  logic [31:0]     s_adr_o, s_dat_o;
  logic [3:0]      s_sel_o;
  logic            s_ack_i, s_err_i, s_rty_i;
  logic [31:0]     s_dat_i;
  logic [NM-1:0]   gnt_o;
  logic            busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int mo   = -1;      // owner index, -1 when idle
  int ml   = NM - 1;  // last granted master
  int msil = 0;       // consecutive strobe cycles without a slave response
  bit merr = 1'b0;    // this cycle is a watchdog ERR cycle
  bit e_stb = 1'b0;

  always #5 clk = ~clk;

  wb_master_arbiter #(.NUM_M(NM), .AW(32), .DW(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_lock_i(m_lock_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o), .m_dat_o(m_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_lock_o(s_lock_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i), .s_dat_i(s_dat_i),
    .gnt_o(gnt_o), .busy_o(busy_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mo = -1; ml = NM - 1; msil = 0; merr = 1'b0;
  endtask

  task automatic check_model();
    logic [NM-1:0] eg, ea, ee, er;
    bit oc, olk;
    eg = '0; ea = '0; ee = '0; er = '0;
    oc = 1'b0; olk = 1'b0; e_stb = 1'b0;
    if (mo >= 0) begin
      eg[mo] = 1'b1;
      oc     = m_cyc_i[mo];
      olk    = m_lock_i[mo];
      e_stb  = m_stb_i[mo] && oc && !merr;
      ea[mo] = s_ack_i && !merr;
      er[mo] = s_rty_i && !merr;
      ee[mo] = s_err_i || merr;
      chk("m_we",  32'(s_we_o),  32'(m_we_i[mo]));
      chk("m_adr", s_adr_o, m_adr_i[mo*32 +: 32]);
      chk("m_wdat", s_dat_o, m_dat_i[mo*32 +: 32]);
      chk("m_sel", 32'(s_sel_o), 32'(m_sel_i[mo*4 +: 4]));
    end
    chk("m_gnt",  32'(gnt_o),    32'(eg));
    chk("m_busy", 32'(busy_o),   32'(mo >= 0));
    chk("m_scyc", 32'(s_cyc_o),  32'(oc));
    chk("m_sstb", 32'(s_stb_o),  32'(e_stb));
    chk("m_lock", 32'(s_lock_o), 32'(olk));
    chk("m_ack",  32'(m_ack_o),  32'(ea));
    chk("m_err",  32'(m_err_o),  32'(ee));
    chk("m_rty",  32'(m_rty_o),  32'(er));
    chk("m_rdat", m_dat_o, s_dat_i);
  endtask

  task automatic model_update();
    bit resp, nerr, found;
    resp = s_ack_i | s_err_i | s_rty_i;
    nerr = 1'b0;
    found = 1'b0;
    if (mo < 0) begin
      msil = 0;
      for (int k = 1; k <= NM; k++)
        if (!found && m_cyc_i[(ml + k) % NM]) begin
          found = 1'b1;
          mo = (ml + k) % NM;
        end
      if (found) ml = mo;
    end else begin
      if (e_stb && !resp) begin
        msil++;
        if (msil == TO) begin nerr = 1'b1; msil = 0; end
      end else msil = 0;
      if (!m_cyc_i[mo] && !m_lock_i[mo]) mo = -1;
    end
    merr = nerr;
  endtask

  // Check at negedge, advance model on posedge, return at posedge+1.
  task automatic tick();
    @(negedge clk);
    check_model();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0; m_lock_i = '0;
    s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
  endtask

  initial begin
    logic [NM-1:0] drop, prevg, lastg;
    int eps, k;
    rst = 1'b0;
    idle_inputs();
    m_adr_i = '0; m_dat_i = '0; m_sel_i = '0; s_dat_i = 32'h1234_5678;
    m_cyc_i = 2'b11; m_stb_i = 2'b11; s_ack_i = 1'b1; s_err_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt",  32'(gnt_o),   0);
    chk("rst_busy", 32'(busy_o),  0);
    chk("rst_scyc", 32'(s_cyc_o), 0);
    chk("rst_sstb", 32'(s_stb_o), 0);
    chk("rst_ack",  32'(m_ack_o), 0);
    chk("rst_err",  32'(m_err_o), 0);
    idle_inputs();
    rst = 1'b1;
    model_reset();

    // single write from master 0
    m_cyc_i = 2'b01; m_stb_i = 2'b01; m_we_i = 2'b01;
    m_adr_i[31:0] = 32'h10; m_dat_i[31:0] = 32'hA5A5_0001; m_sel_i[3:0] = 4'hF;
    tick();
    chk("wr_gnt", 32'(gnt_o), 32'h1);
    chk("wr_adr", s_adr_o, 32'h10);
    chk("wr_dat", s_dat_o, 32'hA5A5_0001);
    s_ack_i = 1'b1; #1;
    chk("wr_ack", 32'(m_ack_o), 32'h1);
    tick();
    idle_inputs();
    tick();
    chk("wr_rel", 32'(gnt_o), 0);

    // both masters continuously issuing single-beat cycles
    drop = '0; prevg = '0; lastg = '0; eps = 0;
    for (int n = 0; n < 16; n++) begin
      m_cyc_i = ~drop; m_stb_i = ~drop;
      #1 s_ack_i = s_stb_o;
      #1 drop = m_ack_o;
      if (gnt_o != 0 && prevg == 0) begin
        eps++;
        if (lastg != 0) chk("rr_alt", 32'(gnt_o), 32'({lastg[0], lastg[1]}));
        lastg = gnt_o;
      end
      if (gnt_o != 0 && prevg != 0) chk("rr_gap", 32'(gnt_o), 32'(prevg));
      prevg = gnt_o;
      tick();
    end
    chk("rr_eps", 32'(eps >= 4), 1);
    idle_inputs();
    tick(); tick();

    // master 0 locks across two cycles while master 1 waits
    m_cyc_i = 2'b01; m_stb_i = 2'b01; m_lock_i = 2'b01;
    tick();
    m_cyc_i = 2'b11; m_stb_i = 2'b11; s_ack_i = 1'b1;
    tick();
    m_cyc_i = 2'b10; m_stb_i = 2'b10; s_ack_i = 1'b0;
    for (int n = 0; n < 2; n++) begin
      tick();
      chk("lk_gnt",  32'(gnt_o),    32'h1);
      chk("lk_lock", 32'(s_lock_o), 1);
      chk("lk_scyc", 32'(s_cyc_o),  0);
    end
    m_cyc_i = 2'b11; m_stb_i = 2'b11; s_ack_i = 1'b1;
    tick();
    m_cyc_i = 2'b10; m_stb_i = 2'b10; m_lock_i = 2'b00; s_ack_i = 1'b0;
    tick();
    chk("lk_gap", 32'(gnt_o), 0);
    tick();
    chk("lk_m1", 32'(gnt_o), 32'h2);
    idle_inputs();
    tick(); tick();

    // watchdog: slave never answers
    m_cyc_i = 2'b01; m_stb_i = 2'b01;
    tick();
    k = 0;
    while (!m_err_o[0] && k < 20) begin tick(); k++; end
    chk("wd_delay", 32'(k), 32'(TO));
    chk("wd_stb",   32'(s_stb_o), 0);
    tick();
    chk("wd_once", 32'(m_err_o), 0);
    s_ack_i = 1'b1; #1;
    chk("wd_after", 32'(m_ack_o), 32'h1);
    tick();
    idle_inputs();
    tick(); tick();

    // retry to master 1, then keep silent strobes; model tracks the cleared count
    m_cyc_i = 2'b10; m_stb_i = 2'b10;
    tick();
    repeat (5) tick();
    s_rty_i = 1'b1; #1;
    chk("rty_m1", 32'(m_rty_o), 32'h2);
    tick();
    s_rty_i = 1'b0;
    repeat (5) tick();

    // asynchronous reset mid-cycle while master 1 owns
    chk("ar_pre", 32'(gnt_o), 32'h2);
    #1 rst = 1'b0; s_ack_i = 1'b1;
    #1;
    chk("ar_gnt",  32'(gnt_o),   0);
    chk("ar_busy", 32'(busy_o),  0);
    chk("ar_scyc", 32'(s_cyc_o), 0);
    chk("ar_sstb", 32'(s_stb_o), 0);
    chk("ar_ack",  32'(m_ack_o), 0);
    @(posedge clk); #1;
    idle_inputs();
    rst = 1'b1;
    model_reset();
    m_cyc_i = 2'b11; m_stb_i = 2'b11;
    tick();
    chk("ar_m0", 32'(gnt_o), 32'h1);
    idle_inputs();
    tick(); tick();

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      for (int j = 0; j < NM; j++) begin
        m_cyc_i[j]  = ($urandom_range(0, 9) < 7);
        m_stb_i[j]  = ($urandom_range(0, 9) < 9);
        m_lock_i[j] = ($urandom_range(0, 9) < 1);
        m_we_i[j]   = $urandom_range(0, 1);
        m_adr_i[j*32 +: 32] = $urandom;
        m_dat_i[j*32 +: 32] = $urandom;
        m_sel_i[j*4 +: 4]   = 4'($urandom_range(0, 15));
      end
      s_ack_i = ($urandom_range(0, 15) == 0);
      s_err_i = ($urandom_range(0, 31) == 0);
      s_rty_i = ($urandom_range(0, 31) == 0);
      s_dat_i = $urandom;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
